// File: rtl/filter_svf_mc_if.sv
// Bus bundle for the multichannel state-variable filter: sample-set input
// handshake, per-channel coefficients, clear, and the filtered output strobe.
// Handshake: a set is taken on a rising clk edge where in_valid && in_ready;
// in_valid seen while in_ready is low is dropped and reported via overrun.
interface filter_svf_mc_if #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH*18-1:0]     F;
  logic [NUM_CH*18-1:0]     Q1;
  logic [NUM_CH*2-1:0]      mode;
  logic                     clear;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     overrun;

  modport master (
    output in_valid, in_data, F, Q1, mode, clear,
    input  in_ready, out_valid, out_data, overrun
  );

  modport slave (
    input  in_valid, in_data, F, Q1, mode, clear,
    output in_ready, out_valid, out_data, overrun
  );
endinterface

// File: rtl/filter_svf_mc.sv
// Time-multiplexed Chamberlin state-variable filter: NUM_CH channels share one
// signed multiplier, three steps (L, H, B) per channel per sample set.
module filter_svf_mc #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  filter_svf_mc_if.slave    bus,
  output logic [1:0]        dbg_state
);

  localparam int S  = DATA_W + 4;
  localparam int PW = 19 + S;
  localparam int AW = PW + 2;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  localparam logic signed [AW-1:0] S_MAX = AW'((64'sd1 <<< (S - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] S_MIN = AW'(-(64'sd1 <<< (S - 1)));
  localparam logic signed [S-1:0]  O_MAX = S'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [S-1:0]  O_MIN = S'(-(1 << (DATA_W - 1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_H = 2'd2,
    CALC_B = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          accept;

  // Captured per-channel operands; frozen between accepts
  logic signed [DATA_W-1:0] in_q    [NUM_CH];
  logic [17:0]              f_q     [NUM_CH];
  logic [17:0]              q_q     [NUM_CH];
  logic [1:0]               mode_q  [NUM_CH];

  logic signed [S-1:0]      l_st    [NUM_CH];
  logic signed [S-1:0]      b_st    [NUM_CH];
  logic signed [S-1:0]      h_q;
  logic signed [DATA_W-1:0] out_stage [NUM_CH];
  logic signed [DATA_W-1:0] out_reg   [NUM_CH];

  function automatic logic signed [AW-1:0] sx_s(input logic signed [S-1:0] v);
    return {{(AW-S){v[S-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] sx_d(input logic signed [DATA_W-1:0] v);
    return {{(AW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [S-1:0] sat_s(input logic signed [AW-1:0] v);
    if (v > S_MAX)      return S_MAX[S-1:0];
    else if (v < S_MIN) return S_MIN[S-1:0];
    else                return v[S-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_o(input logic signed [S-1:0] v);
    if (v > O_MAX)      return O_MAX[DATA_W-1:0];
    else if (v < O_MIN) return O_MIN[DATA_W-1:0];
    else                return v[DATA_W-1:0];
  endfunction

  assign accept = bus.in_valid && (state == IDLE) && !bus.clear;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        idx_n = '0;
        if (accept) state_n = CALC_L;
      end
      CALC_L: state_n = CALC_H;
      CALC_H: state_n = CALC_B;
      CALC_B: begin
        if (idx == LAST) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          state_n = CALC_L;
          idx_n   = idx + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (bus.clear) begin
      state_n = IDLE;
      idx_n   = '0;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready = (state == IDLE);
    dbg_state    = state;
  end

  // Shared multiplier; coefficients are zero-extended so they stay non-negative
  logic signed [18:0]   m_a;
  logic signed [S-1:0]  m_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sh17, sh16;
  logic signed [S-1:0]  l_cur, b_cur, l_new, h_new, b_new, n_new, sel;
  logic signed [DATA_W-1:0] sel_o;

  always_comb begin
    l_cur = l_st[idx];
    b_cur = b_st[idx];
    unique case (state)
      CALC_H: begin
        m_a = $signed({1'b0, q_q[idx]});
        m_b = b_cur;
      end
      CALC_B: begin
        m_a = $signed({1'b0, f_q[idx]});
        m_b = h_q;
      end
      default: begin
        m_a = $signed({1'b0, f_q[idx]});
        m_b = b_cur;
      end
    endcase
    prod  = m_a * m_b;
    sh17  = $signed({{2{prod[PW-1]}}, prod}) >>> 17;
    sh16  = $signed({{2{prod[PW-1]}}, prod}) >>> 16;
    l_new = sat_s(sx_s(l_cur) + sh17);
    h_new = sat_s(sx_d(in_q[idx]) - sx_s(l_cur) - sh16);
    b_new = sat_s(sx_s(b_cur) + sh17);
    // l_cur already holds L' once CALC_L has been written back
    n_new = sat_s(sx_s(h_q) + sx_s(l_cur));
    unique case (mode_q[idx])
      2'b00:   sel = l_cur;
      2'b01:   sel = b_new;
      2'b10:   sel = h_q;
      default: sel = n_new;
    endcase
    sel_o = sat_o(sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      h_q           <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        l_st[k]      <= '0;
        b_st[k]      <= '0;
        in_q[k]      <= '0;
        f_q[k]       <= '0;
        q_q[k]       <= '0;
        mode_q[k]    <= '0;
        out_stage[k] <= '0;
        out_reg[k]   <= '0;
      end
    end else begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= bus.in_valid && (state != IDLE) && !bus.clear;
      if (bus.clear) begin
        for (int k = 0; k < NUM_CH; k++) begin
          l_st[k] <= '0;
          b_st[k] <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              for (int k = 0; k < NUM_CH; k++) begin
                in_q[k]   <= bus.in_data[k*DATA_W +: DATA_W];
                f_q[k]    <= bus.F[k*18 +: 18];
                q_q[k]    <= bus.Q1[k*18 +: 18];
                mode_q[k] <= bus.mode[k*2 +: 2];
              end
            end
          end
          CALC_L: l_st[idx] <= l_new;
          CALC_H: h_q <= h_new;
          CALC_B: begin
            b_st[idx]      <= b_new;
            out_stage[idx] <= sel_o;
            // Publish every channel together so out_data only moves with out_valid
            if (idx == LAST) begin
              bus.out_valid <= 1'b1;
              for (int k = 0; k < NUM_CH; k++)
                out_reg[k] <= (IW'(k) == idx) ? sel_o : out_stage[k];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      bus.out_data[k*DATA_W +: DATA_W] = out_reg[k];
  end

endmodule
